// File: rtl/series_accumulator.sv
// Series-term accumulator: signs and sums Taylor/Maclaurin term magnitudes for
// one evaluation, then returns a saturated fixed-point result with a done pulse.
module series_accumulator #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 20,
  parameter int N_TERMS = 8,
  parameter int IDX_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        func,
  input  logic [DATA_W-1:0] term,
  input  logic              term_valid,
  input  logic              term_last,
  output logic              term_ready,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              sat,
  output logic [IDX_W-1:0]  idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [1:0] FUNC_EXP = 2'b00;
  localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] C_MIN = ~C_MAX;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [1:0]                r_func;
  logic signed [ACC_W-1:0]   r_acc;
  logic [IDX_W-1:0]          r_idx;
  logic [DATA_W-1:0]         r_result;
  logic                      r_done;
  logic                      r_sat;

  logic                      w_accept;
  logic                      w_neg;
  logic                      w_final;
  logic signed [ACC_W-1:0]   w_term_ext;
  logic                      w_hi;
  logic                      w_lo;
  logic [DATA_W-1:0]         w_clip;

  assign w_accept   = term_valid && (r_state == S_ACC);
  // exp is all-positive; the other series alternate starting with a + term
  assign w_neg      = (r_func != FUNC_EXP) && r_idx[0];
  assign w_final    = term_last || (r_idx == IDX_W'(N_TERMS - 1));
  assign w_term_ext = signed'({{(ACC_W - DATA_W){1'b0}}, term});

  assign w_hi   = (r_acc > C_MAX);
  assign w_lo   = (r_acc < C_MIN);
  assign w_clip = w_hi ? C_MAX[DATA_W-1:0] :
                  w_lo ? C_MIN[DATA_W-1:0] : r_acc[DATA_W-1:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_ACC;
      S_ACC:   if (w_accept && w_final) w_state_next = S_FIN;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_func   <= FUNC_EXP;
      r_acc    <= '0;
      r_idx    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_func <= func;
            r_acc  <= '0;
            r_idx  <= '0;
          end
        end
        S_ACC: begin
          if (w_accept) begin
            r_acc <= w_neg ? (r_acc - w_term_ext) : (r_acc + w_term_ext);
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_FIN: begin
          r_result <= w_clip;
          r_sat    <= w_hi || w_lo;
          r_idx    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign term_ready = (r_state == S_ACC);
  assign busy       = (r_state == S_ACC) || (r_state == S_FIN);
  assign result     = r_result;
  assign done       = r_done;
  assign sat        = r_sat;
  assign idx        = r_idx;

endmodule

// File: tb/tb_series_accumulator.sv
// Randomized scoreboard bench for series_accumulator: a plain-arithmetic model of
// the signed series sum predicts each result; a monitor checks every done pulse.
module tb_series_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  func;
  logic [15:0] term;
  logic        term_valid;
  logic        term_last;
  logic        term_ready;
  logic [15:0] result;
  logic        done;
  logic        busy;
  logic        sat;
  logic [2:0]  idx;

  series_accumulator #(.DATA_W(16), .ACC_W(20), .N_TERMS(8), .IDX_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .func       (func),
    .term       (term),
    .term_valid (term_valid),
    .term_last  (term_last),
    .term_ready (term_ready),
    .result     (result),
    .done       (done),
    .busy       (busy),
    .sat        (sat),
    .idx        (idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int sat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   tv[8];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   prev_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: signed sum of the first n terms, then clamp to the 16-bit range.
  function automatic exp_t model(input logic [1:0] f, input int n);
    exp_t    e;
    longint  s = 0;
    for (int i = 0; i < n; i++) begin
      if (f != 2'b00 && (i % 2) == 1) s -= tv[i];
      else                            s += tv[i];
    end
    e.sat = 0;
    if (s > 32767)       begin e.res = 32767;  e.sat = 1; end
    else if (s < -32768) begin e.res = -32768; e.sat = 1; end
    else                 e.res = int'(s);
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      check("done_single_pulse", prev_done, 0);
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1, expected no pending result (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("result", int'($signed(result)), e.res);
        check("sat", int'(sat), e.sat);
        check("done_latency", cyc, e.cyc);
      end
    end
    prev_done = int'(done);
  end

  // Caller must be positioned just after a rising edge.
  task automatic run_eval(input logic [1:0] f, input int n, input bit use_last,
                          input int gapmax, input bit mid_start, input bit extra,
                          input bit chain, input int abort_at);
    exp_t e;
    int   g;
    int   cnt;
    start = 1'b1;
    func  = f;
    @(posedge clk); #1;
    start = 1'b0;
    func  = 2'($urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      if (mid_start && i == 1) start = 1'b1;
      term       = 16'(tv[i]);
      term_valid = 1'b1;
      term_last  = use_last && (i == n - 1);
      @(negedge clk);
      check("term_ready_acc", int'(term_ready), 1);
      check("idx_acc", int'(idx), i);
      check("busy_acc", int'(busy), 1);
      @(posedge clk); #1;
      term_valid = 1'b0;
      term_last  = 1'b0;
      start      = 1'b0;
      if (i == abort_at - 1) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_result", int'(result), 0);
        check("rst_done", int'(done), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_idx", int'(idx), 0);
        check("rst_ready", int'(term_ready), 0);
        @(posedge clk); #1;
        return;
      end
    end
    e     = model(f, n);
    e.cyc = cyc + 1;
    sb.push_back(e);
    if (extra) begin
      term       = 16'hFFFF;
      term_valid = 1'b1;
      @(negedge clk);
      check("term_ready_fin", int'(term_ready), 0);
      @(posedge clk); #1;
      term_valid = 1'b0;
    end
    if (chain) begin
      if (!extra) begin @(posedge clk); #1; end
      return;
    end
    cnt = 0;
    while (sb.size() != 0 && cnt < 8) begin
      @(posedge clk); #1;
      cnt++;
    end
    @(negedge clk);
    check("result_drained", sb.size(), 0);
    check("idx_rest", int'(idx), 0);
    check("busy_rest", int'(busy), 0);
    if (sb.size() != 0) sb.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; func = 2'b00;
    term = '0; term_valid = 1'b0; term_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    check("reset_sat", int'(sat), 0);
    check("reset_idx", int'(idx), 0);
    check("reset_ready", int'(term_ready), 0);
    @(posedge clk); #1;

    // exp, 8 terms, last on the 8th
    tv = '{8192, 8192, 4096, 1365, 341, 68, 11, 1};
    run_eval(2'b00, 8, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1);
    $display("exp 8-term run complete: result=%0d", $signed(result));
    // sin, 4 terms
    tv = '{8192, 1365, 68, 1, 0, 0, 0, 0};
    run_eval(2'b01, 4, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1);
    $display("sin 4-term run complete: result=%0d", $signed(result));
    // positive saturation, then ln chained into the done cycle
    tv = '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
    run_eval(2'b00, 8, 1'b1, 0, 1'b0, 1'b0, 1'b1, -1);
    tv = '{0, 30000, 0, 30000, 0, 0, 0, 0};
    run_eval(2'b11, 4, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1);
    $display("saturation runs complete: result=%0d sat=%0d", $signed(result), sat);
    // cos with gaps and a mid-run start, then gap-free
    tv = '{8192, 4096, 341, 11, 0, 0, 0, 0};
    run_eval(2'b10, 4, 1'b1, 5, 1'b1, 1'b0, 1'b0, -1);
    run_eval(2'b10, 4, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1);
    $display("cos gap/no-gap runs complete: result=%0d", $signed(result));
    // reset abort after 2nd term, then a fresh exp run
    tv = '{8192, 8192, 4096, 1365, 341, 68, 11, 1};
    run_eval(2'b00, 8, 1'b1, 0, 1'b0, 1'b0, 1'b0, 2);
    run_eval(2'b00, 8, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1);
    $display("abort and rerun complete: result=%0d", $signed(result));
    // terms offered in IDLE are ignored
    term = 16'd1234; term_valid = 1'b1; term_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", int'(term_ready), 0);
      check("idle_busy", int'(busy), 0);
    end
    @(posedge clk); #1;
    term_valid = 1'b0; term_last = 1'b0;
    // 8 terms without term_last stop at N_TERMS; a 9th term is refused
    tv = '{100, 200, 300, 400, 500, 600, 700, 800};
    run_eval(2'b01, 8, 1'b0, 0, 1'b0, 1'b1, 1'b0, -1);
    $display("N_TERMS boundary run complete: result=%0d", $signed(result));

    for (int r = 0; r < 30; r++) begin
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < 8; i++)
        tv[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                            : int'($urandom_range(0, 9000));
      run_eval(2'($urandom_range(0, 3)), n, (n < 8) ? 1'b1 : 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'($urandom_range(0, 1)), -1);
      $display("random run %0d: %0d terms, result=%0d sat=%0d", r, n, $signed(result), sat);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("final_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
